// File: rtl/vdp_mac_sched.sv
// Sequencer for the shared signed MAC in the vdp benchmark. It streams K (g,e) pairs into
// the MAC, clears the MAC between vectors, and presents the dot product on valid/ready.
module vdp_mac_sched #(
    parameter int N = 8,
    parameter int K = 4,
    parameter int L = 2*(N-1)+K
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] in_g,
    input  logic signed [N-1:0] in_e,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [L-1:0] out_data,
    output logic                err,
    output logic                mac_clr,
    output logic signed [N-1:0] mac_g,
    output logic signed [N-1:0] mac_e,
    input  logic signed [L-1:0] mac_o
);
    localparam int CW = $clog2(K+1);
    localparam logic [CW-1:0] LAST_IDX = CW'(K-1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, CAP = 2'd2, HOLD = 2'd3} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          accept;
    logic          idx_last;

    assign in_ready = rst && ((state == IDLE) || (state == ACC));
    assign accept   = in_valid && in_ready;
    assign idx_last = (cnt == LAST_IDX);

    // Operands reach the MAC only on an accepted beat, so bubbles add zero.
    assign mac_g = accept ? in_g : '0;
    assign mac_e = accept ? in_e : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt   = CW'(1);
                    state_nxt = (K == 1) ? CAP : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    cnt_nxt = cnt + CW'(1);
                    if (idx_last) state_nxt = CAP;
                end
            end
            CAP: state_nxt = HOLD;
            HOLD: begin
                if (out_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The MAC is held cleared whenever no vector is in flight, including during reset.
    always_comb begin
        mac_clr = 1'b1;
        if (rst) begin
            unique case (state)
                IDLE:    mac_clr = ~accept;
                ACC:     mac_clr = 1'b0;
                CAP:     mac_clr = 1'b0;
                HOLD:    mac_clr = 1'b1;
                default: mac_clr = 1'b1;
            endcase
        end
    end

    // Framing is only checked: the element count alone decides when a vector ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            if (state == CAP) begin
                out_valid <= 1'b1;
                out_data  <= mac_o;
            end else if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && (in_last != idx_last)) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vdp_mac_sched.sv
// Bench for vdp_mac_sched: table vectors, hand-written corner sequences and random vectors
// checked against a dot-product scoreboard; a second instance covers K=1.
module tb_vdp_mac_sched;
    localparam int N  = 8;
    localparam int K  = 4;
    localparam int L  = 2*(N-1)+K;
    localparam int L1 = 2*(N-1)+1;
    localparam int NTAB = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [N-1:0] in_g = '0;
    logic signed [N-1:0] in_e = '0;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready;
    logic signed [L-1:0] out_data;
    logic                err;
    logic                mac_clr;
    logic signed [N-1:0] mac_g;
    logic signed [N-1:0] mac_e;
    logic signed [L-1:0] mac_o;

    vdp_mac_sched #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_g(in_g), .in_e(in_e), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err),
        .mac_clr(mac_clr), .mac_g(mac_g), .mac_e(mac_e), .mac_o(mac_o)
    );

    logic signed [L-1:0] acc;
    logic signed [L-1:0] prod;
    assign prod  = L'(mac_g) * L'(mac_e);
    assign mac_o = acc;
    always @(posedge clk) acc <= mac_clr ? '0 : acc + prod;

    logic                 k1_valid = 1'b0;
    logic                 k1_ready;
    logic signed [N-1:0]  k1_g = '0;
    logic signed [N-1:0]  k1_e = '0;
    logic                 k1_last = 1'b0;
    logic                 k1_out_valid;
    logic                 k1_out_ready = 1'b1;
    logic signed [L1-1:0] k1_out_data;
    logic                 k1_err;
    logic                 k1_mac_clr;
    logic signed [N-1:0]  k1_mac_g;
    logic signed [N-1:0]  k1_mac_e;
    logic signed [L1-1:0] k1_acc;
    logic signed [L1-1:0] k1_prod;
    assign k1_prod = L1'(k1_mac_g) * L1'(k1_mac_e);
    always @(posedge clk) k1_acc <= k1_mac_clr ? '0 : k1_acc + k1_prod;

    vdp_mac_sched #(.N(N), .K(1)) dut_k1 (
        .clk(clk), .rst(rst),
        .in_valid(k1_valid), .in_ready(k1_ready), .in_g(k1_g), .in_e(k1_e), .in_last(k1_last),
        .out_valid(k1_out_valid), .out_ready(k1_out_ready), .out_data(k1_out_data), .err(k1_err),
        .mac_clr(k1_mac_clr), .mac_g(k1_mac_g), .mac_e(k1_mac_e), .mac_o(k1_acc)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted pairs are grouped K at a time into plain-integer dot products.
    int                  m_idx = 0;
    longint              m_sum = 0;
    bit                  m_err = 1'b0;
    logic signed [L-1:0] expq[$];

    int     cyc = 0;
    int     n_out = 0;
    int     vcnt = 0;
    longint out_log[$];
    int     out_cyc[$];
    int     rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = 1'b0;
            else                    out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst && out_valid) vcnt++;
            if (rst && out_valid && out_ready) begin
                if (expq.size() == 0) chk("unexpected_result", 1, 0);
                else chk("scoreboard_data", longint'(out_data), longint'(expq.pop_front()));
                out_log.push_back(longint'(out_data));
                out_cyc.push_back(cyc);
                n_out++;
            end
        end
    end

    task automatic push(input logic signed [N-1:0] g, input logic signed [N-1:0] e,
                        input logic last, input int bub);
        int t;
        for (int b = 0; b < bub; b++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (m_idx > 0) begin
                chk("bubble_mac_g", longint'(mac_g), 0);
                chk("bubble_mac_e", longint'(mac_e), 0);
                chk("bubble_mac_clr", longint'(mac_clr), 0);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_g     = g;
        in_e     = e;
        in_last  = last;
        #1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        chk("accept_mac_g", longint'(mac_g), longint'(g));
        chk("accept_mac_clr", longint'(mac_clr), 0);
        @(posedge clk);
        m_sum = m_sum + longint'(g) * longint'(e);
        if (last != (m_idx == K-1)) m_err = 1'b1;
        m_idx++;
        if (m_idx == K) begin
            expq.push_back(L'(m_sum));
            m_idx = 0;
            m_sum = 0;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int t = 0;
        while (n_out < target && t < 1000) begin
            @(negedge clk);
            #3;
            t++;
        end
        chk("result_timeout", longint'(n_out >= target), 1);
    endtask

    typedef struct {
        int g[K];
        int e[K];
        int last_idx;
        int bub;
        bit chain;
        int exp_out;
        bit exp_err;
    } vec_t;

    vec_t tab[NTAB];

    task automatic set_vec(input int i, input int g0, input int g1, input int g2, input int g3,
                           input int e0, input int e1, input int e2, input int e3,
                           input int li, input int bub, input bit chain, input int ex,
                           input bit ee);
        tab[i].g[0] = g0; tab[i].g[1] = g1; tab[i].g[2] = g2; tab[i].g[3] = g3;
        tab[i].e[0] = e0; tab[i].e[1] = e1; tab[i].e[2] = e2; tab[i].e[3] = e3;
        tab[i].last_idx = li;
        tab[i].bub      = bub;
        tab[i].chain    = chain;
        tab[i].exp_out  = ex;
        tab[i].exp_err  = ee;
    endtask

    int exp_n = 0;
    int unchk = 0;
    int t_wait;

    initial begin
        set_vec(0, 127, 23, -23, -23, -127, 99, 99, -99, 3, 0, 1'b1, -13852, 1'b0);
        set_vec(1, 127, 23, -23, -23, -127, 99, 99, -99, 3, 0, 1'b0, -13852, 1'b0);
        set_vec(2, 127, 23, -23, -23, -127, 99, 99, -99, 3, 1, 1'b0, -13852, 1'b0);
        set_vec(3, -128, -128, -128, -128, -128, -128, -128, -128, 3, 0, 1'b0, 65536, 1'b0);
        set_vec(4, 127, 127, 127, 127, -128, -128, -128, -128, 3, 2, 1'b0, -65024, 1'b0);
        set_vec(5, 3, -5, 7, -9, -2, 4, -6, 8, 3, 0, 1'b0, -140, 1'b0);
        set_vec(6, 127, 23, -23, -23, -127, 99, 99, -99, 1, 0, 1'b0, -13852, 1'b1);

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_mac_clr", longint'(mac_clr), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_err", longint'(err), 0);
        chk("rst_k1_out_valid", longint'(k1_out_valid), 0);
        @(negedge clk);
        rst = 1'b1;

        // K=1: one accepted pair is the whole vector.
        @(negedge clk);
        k1_valid = 1'b1;
        k1_g     = 8'sd127;
        k1_e     = -8'sd128;
        k1_last  = 1'b1;
        #1;
        chk("k1_in_ready", longint'(k1_ready), 1);
        @(posedge clk);
        #1;
        k1_valid = 1'b0;
        chk("k1_valid_early", longint'(k1_out_valid), 0);
        @(posedge clk);
        #1;
        chk("k1_out_valid", longint'(k1_out_valid), 1);
        chk("k1_out_data", longint'(k1_out_data), -16256);
        chk("k1_err", longint'(k1_err), 0);

        // Table vectors, out_ready held high.
        rdy_mode = 0;
        for (int i = 0; i < NTAB; i++) begin
            for (int j = 0; j < K; j++)
                push(N'(tab[i].g[j]), N'(tab[i].e[j]), (j == tab[i].last_idx),
                     (j == 0) ? 0 : tab[i].bub);
            exp_n++;
            if (!tab[i].chain) begin
                wait_out(exp_n);
                for (int v = unchk; v <= i; v++) begin
                    if (v < out_log.size()) chk("table_result", out_log[v], longint'(tab[v].exp_out));
                    else chk("table_result_missing", 0, 1);
                end
                unchk = i + 1;
                chk("table_err", longint'(err), longint'(tab[i].exp_err));
                chk("model_err", longint'(err), longint'(m_err));
            end
        end
        if (out_cyc.size() >= 2) chk("vector_period", longint'(out_cyc[1] - out_cyc[0]), K+2);
        else chk("vector_period_missing", 0, 1);
        chk("out_valid_pulses", longint'(vcnt), NTAB);

        // Backpressure: result held while out_ready stays low, no new element taken.
        rdy_mode = 1;
        for (int j = 0; j < K; j++)
            push(N'(tab[0].g[j]), N'(tab[0].e[j]), (j == K-1), 0);
        exp_n++;
        t_wait = 0;
        @(negedge clk);
        #2;
        while (!out_valid && t_wait < 20) begin
            @(negedge clk);
            #2;
            t_wait++;
        end
        for (int c = 0; c < 5; c++) begin
            chk("hold_out_valid", longint'(out_valid), 1);
            chk("hold_out_data", longint'(out_data), -13852);
            chk("hold_in_ready", longint'(in_ready), 0);
            in_valid = 1'b1;
            in_g     = 8'sd99;
            in_e     = 8'sd99;
            @(negedge clk);
            #2;
        end
        in_valid = 1'b0;
        @(posedge clk);
        rdy_mode = 0;
        wait_out(exp_n);
        for (int j = 0; j < K; j++) push(8'sd1, 8'sd2, (j == K-1), 0);
        exp_n++;
        wait_out(exp_n);
        chk("after_hold_result", out_log[out_log.size()-1], 8);
        chk("err_sticky", longint'(err), 1);

        // Asynchronous reset in the middle of a vector.
        push(8'sd50, 8'sd3, 1'b0, 0);
        push(8'sd60, 8'sd3, 1'b0, 0);
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        m_idx = 0;
        m_sum = 0;
        m_err = 1'b0;
        chk("arst_in_ready", longint'(in_ready), 0);
        chk("arst_mac_clr", longint'(mac_clr), 1);
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_out_data", longint'(out_data), 0);
        chk("arst_err", longint'(err), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < K; j++) push(N'(j + 1), 8'sd1, (j == K-1), 0);
        exp_n++;
        wait_out(exp_n);
        chk("post_reset_result", out_log[out_log.size()-1], 10);
        chk("post_reset_err", longint'(err), 0);

        // Random vectors with random bubbles and random backpressure.
        rdy_mode = 2;
        for (int v = 0; v < 20; v++) begin
            for (int j = 0; j < K; j++)
                push(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)), (j == K-1),
                     $urandom_range(0, 2));
            exp_n++;
        end
        wait_out(exp_n);
        chk("random_err", longint'(err), longint'(m_err));
        chk("random_queue_drained", longint'(expq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
